// File: rtl/display_pkg.sv
// Shared types and constants for the display scan controller: scan states,
// RGB channel layout in memory words and the bit-plane display length helper.
package display_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREFETCH,
        SHIFT,
        LATCH,
        DISPLAY
    } scan_state_t;

    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;
    localparam int CH_W  = 8;

    // Binary-coded modulation: each plane is lit twice as long as the one below it.
    function automatic int plane_ticks(input int base_ticks, input int plane);
        return base_ticks << plane;
    endfunction

endpackage

// File: rtl/display_scan_controller_bcm_timer.sv
// Loadable down-counter shared by the column shift and the plane display phases.
// With DISPLAY_SCAN_BRIGHTNESS_EN it also flags the leading part of a count window.
module bcm_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    input  logic [W-1:0] cmp_val,
    output logic         cmp_hit,
`endif
    output logic [W-1:0] count,
    output logic         done
);

    logic [W-1:0] cnt;

    // A load of N yields N counting cycles: N-1 down to 0, done on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val - 1'b1;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    logic [W-1:0] cmp_level;

    // Elapsed < cmp_val is the same as remaining >= load_val - cmp_val.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_level <= '0;
        end else if (load) begin
            cmp_level <= load_val - cmp_val;
        end
    end

    assign cmp_hit = (cnt >= cmp_level);
`endif

    assign count = cnt;
    assign done  = (cnt == '0);

endmodule

// File: rtl/display_scan_controller.sv
// HUB75 frame scan sequencer with BCM timing over a double-buffered display memory.
// Optional feature macro: DISPLAY_SCAN_BRIGHTNESS_EN (adds brightness[7:0] input).
module display_scan_controller #(
    parameter int ROWS       = 8,
    parameter int COLUMNS    = 32,
    parameter int BITS       = 8,
    parameter int BASE_TICKS = 1,
    parameter int ROW_W      = $clog2(ROWS),
    parameter int COL_W      = $clog2(COLUMNS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             flip_req,
    output logic             flip_ack,
    output logic             flip,
    output logic [ROW_W-1:0] rrow,
    output logic [COL_W-1:0] rcol,
    input  logic [23:0]      rdata,
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    input  logic [7:0]       brightness,
`endif
    output logic [2:0]       rgb,
    output logic             sclk,
    output logic             lat,
    output logic             oe_n,
    output logic [ROW_W-1:0] addr
);

    import display_pkg::*;

    localparam int PLANE_W   = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int SHIFT_LEN = 2 * COLUMNS;
    localparam int MAX_TICKS = BASE_TICKS << (BITS - 1);
    localparam int TMR_W     = $clog2(((SHIFT_LEN > MAX_TICKS) ? SHIFT_LEN : MAX_TICKS) + 1);

    scan_state_t        state, state_n;
    logic [ROW_W-1:0]   row, row_n, rrow_n, addr_n;
    logic [PLANE_W-1:0] plane, plane_n;
    logic [COL_W-1:0]   rcol_n, col;
    logic [2:0]         rgb_n;
    logic               sclk_n, lat_n, oe_n_n, flip_n, flip_ack_n;
    logic               flip_pending, pending_n, frame_end;
    logic               tmr_load, tmr_done;
    logic [TMR_W-1:0]   tmr_val, tmr_cnt, plane_len;
    logic [CH_W-1:0]    r_chan, g_chan, b_chan;

    assign r_chan    = rdata[R_LSB +: CH_W];
    assign g_chan    = rdata[G_LSB +: CH_W];
    assign b_chan    = rdata[B_LSB +: CH_W];
    assign plane_len = TMR_W'(plane_ticks(BASE_TICKS, int'(plane)));

    // The shift window counts down from 2*COLUMNS-1, so odd counts are the data cycles.
    assign col = COL_W'(COLUMNS - 1) - COL_W'(tmr_cnt >> 1);

`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    localparam int PROD_W = TMR_W + 9;

    logic [PROD_W-1:0] bright_prod;
    logic [TMR_W-1:0]  bright_thr;
    logic              tmr_hit;

    assign bright_prod = PROD_W'(plane_len) * (PROD_W'(brightness) + PROD_W'(1));
    assign bright_thr  = TMR_W'(bright_prod >> 8);
`endif

    bcm_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
        .cmp_val  (bright_thr),
        .cmp_hit  (tmr_hit),
`endif
        .count    (tmr_cnt),
        .done     (tmr_done)
    );

    always_comb begin
        state_n    = state;
        row_n      = row;
        plane_n    = plane;
        rrow_n     = rrow;
        rcol_n     = rcol;
        rgb_n      = rgb;
        addr_n     = addr;
        sclk_n     = 1'b0;
        lat_n      = 1'b0;
        oe_n_n     = 1'b1;
        flip_n     = flip;
        flip_ack_n = 1'b0;
        pending_n  = flip_pending | flip_req;
        frame_end  = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;

        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_n = PREFETCH;
                    rrow_n  = row;
                    rcol_n  = '0;
                end
            end

            PREFETCH: begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(SHIFT_LEN);
                state_n  = SHIFT;
            end

            // Memory data for column k arrives on the data cycle; the next address goes out with it.
            SHIFT: begin
                if (tmr_cnt[0]) begin
                    rgb_n  = {r_chan[plane], g_chan[plane], b_chan[plane]};
                    rcol_n = (col == COL_W'(COLUMNS - 1)) ? col : col + 1'b1;
                end else begin
                    sclk_n = 1'b1;
                end
                if (tmr_done) begin
                    state_n = LATCH;
                end
            end

            LATCH: begin
                lat_n    = 1'b1;
                addr_n   = row;
                tmr_load = 1'b1;
                tmr_val  = plane_len;
                state_n  = DISPLAY;
            end

            DISPLAY: begin
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
                oe_n_n = ~tmr_hit;
`else
                oe_n_n = 1'b0;
`endif
                if (tmr_done) begin
                    if (plane == PLANE_W'(BITS - 1)) begin
                        plane_n = '0;
                        if (row == ROW_W'(ROWS - 1)) begin
                            row_n     = '0;
                            frame_end = 1'b1;
                        end else begin
                            row_n = row + 1'b1;
                        end
                    end else begin
                        plane_n = plane + 1'b1;
                    end

                    // Buffers swap only here, so a frame is never shown from two buffers.
                    if (frame_end && pending_n) begin
                        flip_n     = ~flip;
                        flip_ack_n = 1'b1;
                        pending_n  = 1'b0;
                    end

                    if (enable) begin
                        state_n = PREFETCH;
                        rrow_n  = row_n;
                        rcol_n  = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            row          <= '0;
            plane        <= '0;
            rrow         <= '0;
            rcol         <= '0;
            rgb          <= '0;
            addr         <= '0;
            sclk         <= 1'b0;
            lat          <= 1'b0;
            oe_n         <= 1'b1;
            flip         <= 1'b0;
            flip_ack     <= 1'b0;
            flip_pending <= 1'b0;
        end else begin
            state        <= state_n;
            row          <= row_n;
            plane        <= plane_n;
            rrow         <= rrow_n;
            rcol         <= rcol_n;
            rgb          <= rgb_n;
            addr         <= addr_n;
            sclk         <= sclk_n;
            lat          <= lat_n;
            oe_n         <= oe_n_n;
            flip         <= flip_n;
            flip_ack     <= flip_ack_n;
            flip_pending <= pending_n;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller: a memory model feeds rdata and a
// scoreboard of expected pixels, latch addresses and lit lengths is checked as the panel runs.
module tb_display_scan_controller;

    localparam int ROWS         = 8;
    localparam int COLUMNS      = 32;
    localparam int BITS         = 8;
    localparam int BASE_TICKS   = 1;
    localparam int ROW_W        = 3;
    localparam int COL_W        = 5;
    localparam int ROW_CYCLES   = 783;
    localparam int FRAME_CYCLES = 6264;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b1;
    logic             enable   = 1'b0;
    logic             flip_req = 1'b0;
    logic             flip_ack, flip;
    logic [ROW_W-1:0] rrow, addr;
    logic [COL_W-1:0] rcol;
    logic [23:0]      rdata;
    logic [2:0]       rgb;
    logic             sclk, lat, oe_n;
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    logic [7:0]       brightness = 8'hFF;
`endif

    int errors = 0;
    int checks = 0;

    logic [23:0]      mem [ROWS][COLUMNS];
    logic [2:0]       exp_rgb [$];
    logic [ROW_W-1:0] exp_addr [$];
    int               exp_len [$];
    int               lat_cycle [$];
    logic             lat_flip [$];

    int         cyc       = 0;
    int         lat_count = 0;
    int         ack_count = 0;
    int         ack_cycle = 0;
    int         run       = 0;
    int         rises     = 0;
    bit         mon_on    = 1'b0;
    logic       prev_sclk = 1'b0;
    logic [2:0] mon_rgb;
    logic [ROW_W-1:0] mon_addr;
    int         mon_len;

    display_scan_controller #(
        .ROWS       (ROWS),
        .COLUMNS    (COLUMNS),
        .BITS       (BITS),
        .BASE_TICKS (BASE_TICKS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .flip_req   (flip_req),
        .flip_ack   (flip_ack),
        .flip       (flip),
        .rrow       (rrow),
        .rcol       (rcol),
        .rdata      (rdata),
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .rgb        (rgb),
        .sclk       (sclk),
        .lat        (lat),
        .oe_n       (oe_n),
        .addr       (addr)
    );

    always #5 clk = ~clk;

    // Synchronous read port model with one cycle of latency.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rdata <= mem[rrow][rcol];
    end

    // Scoreboard monitor: pixels at sclk rise, address at lat, lit length at oe_n release.
    always @(negedge clk) begin
        if (mon_on) begin
            if (sclk === 1'b1 && prev_sclk === 1'b0) begin
                rises++;
                checks++;
                if (exp_rgb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rgb_unexpected: sclk rise with rgb=%b, required no shift", rgb);
                end else begin
                    mon_rgb = exp_rgb.pop_front();
                    if (rgb !== mon_rgb) begin
                        errors++;
                        $display("[TB] FAIL rgb: got %b required %b (cycle %0d)", rgb, mon_rgb, cyc);
                    end
                end
            end
            if (lat === 1'b1) begin
                checks++;
                if (rises !== COLUMNS) begin
                    errors++;
                    $display("[TB] FAIL rises_before_lat: got %0d required %0d", rises, COLUMNS);
                end
                rises = 0;
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL lat_unexpected: lat with addr=%0d, required none", addr);
                end else begin
                    mon_addr = exp_addr.pop_front();
                    if (addr !== mon_addr) begin
                        errors++;
                        $display("[TB] FAIL addr: got %0d required %0d", addr, mon_addr);
                    end
                end
                lat_cycle.push_back(cyc);
                lat_flip.push_back(flip);
                lat_count++;
            end
            if (oe_n === 1'b0) begin
                run++;
            end else if (run > 0) begin
                checks++;
                if (exp_len.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL oe_unexpected: lit for %0d cycles, required none", run);
                end else begin
                    mon_len = exp_len.pop_front();
                    if (run !== mon_len) begin
                        errors++;
                        $display("[TB] FAIL oe_len: got %0d required %0d", run, mon_len);
                    end
                end
                run = 0;
            end
            if (flip_ack === 1'b1) begin
                ack_count++;
                ack_cycle = cyc;
            end
        end else begin
            run   = 0;
            rises = 0;
        end
        prev_sclk = sclk;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_rowplane(input int r, input int p);
        logic [23:0] px;
        for (int k = 0; k < COLUMNS; k++) begin
            px = mem[r][k];
            exp_rgb.push_back({px[16 + p], px[8 + p], px[p]});
        end
        exp_addr.push_back(ROW_W'(r));
        exp_len.push_back(BASE_TICKS << p);
    endtask

    task automatic wait_lats(input int target, input int budget, input string what);
        int n;
        n = 0;
        while (lat_count < target && n < budget) begin
            step();
            n++;
        end
        if (lat_count < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: lat_count=%0d required %0d", what, lat_count, target);
        end
    endtask

    task automatic test_reset();
        logic [18:0] got;
        #1 rst_n = 1'b0;
        enable   = 1'b0;
        repeat (5) step();
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            got = {oe_n, sclk, lat, flip, flip_ack, rcol, rrow, addr, rgb};
            checks++;
            if (got !== {1'b1, 18'd0}) begin
                errors++;
                $display("[TB] FAIL reset_idle: got %b required %b at cycle %0d", got, {1'b1, 18'd0}, i);
            end
        end
    endtask

    task automatic test_frame_scan();
        int base;
        base = lat_count;
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < ROWS; r++)
                for (int p = 0; p < BITS; p++)
                    push_rowplane(r, p);
        mon_on = 1'b1;
        enable = 1'b1;
        repeat (100) step();
        flip_req = 1'b1;
        step();
        flip_req = 1'b0;
        repeat (99) step();
        flip_req = 1'b1;
        step();
        flip_req = 1'b0;
        wait_lats(base + 2 * ROWS * BITS, 3 * FRAME_CYCLES, "frame");

        checks++;
        if (lat_cycle[base + 1] - lat_cycle[base] !== 2 + 2 * COLUMNS + BASE_TICKS) begin
            errors++;
            $display("[TB] FAIL plane0_period: got %0d required %0d",
                     lat_cycle[base + 1] - lat_cycle[base], 2 + 2 * COLUMNS + BASE_TICKS);
        end
        checks++;
        if (lat_cycle[base + BITS] - lat_cycle[base] !== ROW_CYCLES) begin
            errors++;
            $display("[TB] FAIL row_period: got %0d required %0d",
                     lat_cycle[base + BITS] - lat_cycle[base], ROW_CYCLES);
        end
        checks++;
        if (lat_cycle[base + 64] - lat_cycle[base] !== FRAME_CYCLES) begin
            errors++;
            $display("[TB] FAIL frame_period: got %0d required %0d",
                     lat_cycle[base + 64] - lat_cycle[base], FRAME_CYCLES);
        end
        checks++;
        if (lat_flip[base + 63] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flip_mid_frame: got %b required 0", lat_flip[base + 63]);
        end
        checks++;
        if (lat_flip[base + 64] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flip_after_frame: got %b required 1", lat_flip[base + 64]);
        end
        checks++;
        if (lat_flip[base + 127] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flip_second_frame: got %b required 1", lat_flip[base + 127]);
        end
        checks++;
        if (ack_count !== 1) begin
            errors++;
            $display("[TB] FAIL flip_ack_count: got %0d required 1", ack_count);
        end
        checks++;
        if (!(ack_cycle > lat_cycle[base + 63] && ack_cycle < lat_cycle[base + 64])) begin
            errors++;
            $display("[TB] FAIL flip_ack_window: got cycle %0d required between %0d and %0d",
                     ack_cycle, lat_cycle[base + 63], lat_cycle[base + 64]);
        end
    endtask

    task automatic test_enable_drop();
        int base;
        base = lat_count;
        for (int i = 0; i <= 26; i++) push_rowplane(i / BITS, i % BITS);
        wait_lats(base + 26, 2 * FRAME_CYCLES, "row3_plane1");
        repeat (15) step();
        enable = 1'b0;
        wait_lats(base + 27, 500, "row3_plane2");
        repeat (10) step();
        for (int i = 0; i < 50; i++) begin
            step();
            checks++;
            if ({oe_n, sclk} !== 2'b10) begin
                errors++;
                $display("[TB] FAIL parked: got oe_n,sclk=%b required 10 at idle cycle %0d", {oe_n, sclk}, i);
            end
        end
        checks++;
        if (exp_rgb.size() + exp_addr.size() + exp_len.size() !== 0) begin
            errors++;
            $display("[TB] FAIL parked_queue: got %0d pending required 0",
                     exp_rgb.size() + exp_addr.size() + exp_len.size());
        end
        checks++;
        if (lat_flip[base] !== 1'b1 || ack_count !== 1) begin
            errors++;
            $display("[TB] FAIL no_flip_frame2: got flip=%b acks=%0d required flip=1 acks=1",
                     lat_flip[base], ack_count);
        end
        push_rowplane(3, 3);
        enable = 1'b1;
        wait_lats(base + 28, 500, "resume_row3_plane3");
    endtask

    task automatic test_async_reset();
        logic [17:0] got;
        int lc;
        repeat (3) step();
        checks++;
        if (oe_n !== 1'b0) begin
            errors++;
            $display("[TB] FAIL in_display: got oe_n=%b required 0", oe_n);
        end
        mon_on = 1'b0;
        checks++;
        if (exp_rgb.size() + exp_addr.size() !== 0 || exp_len.size() !== 1) begin
            errors++;
            $display("[TB] FAIL abort_queue: got %0d/%0d/%0d required 0/0/1",
                     exp_rgb.size(), exp_addr.size(), exp_len.size());
        end
        exp_len.delete();
        #2 rst_n = 1'b0;
        #1;
        got = {oe_n, sclk, lat, flip, rcol, rrow, addr, rgb};
        checks++;
        if (got !== {1'b1, 17'd0}) begin
            errors++;
            $display("[TB] FAIL async_reset: got %b required %b", got, {1'b1, 17'd0});
        end
        push_rowplane(0, 0);
        enable = 1'b1;
        step();
        mon_on = 1'b1;
        rst_n  = 1'b1;
        repeat (20) step();
        enable = 1'b0;
        lc = lat_count;
        wait_lats(lc + 1, 500, "restart_row0_plane0");
        repeat (20) step();
        checks++;
        if (exp_rgb.size() + exp_addr.size() + exp_len.size() !== 0) begin
            errors++;
            $display("[TB] FAIL restart_queue: got %0d pending required 0",
                     exp_rgb.size() + exp_addr.size() + exp_len.size());
        end
        checks++;
        if ({flip, oe_n} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL restart_state: got flip,oe_n=%b required 01", {flip, oe_n});
        end
    endtask

    initial begin
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLUMNS; k++)
                mem[r][k] = (r == 0) ? ((k % 2 == 0) ? 24'h800001 : 24'h000000) : 24'($urandom);
        $display("[TB] starting display_scan_controller bench");
        test_reset();
        test_frame_scan();
        test_enable_drop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
